multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM. Sequences the shared datapath (one memory port, ALU, regfile).
//  Decodes op/funct and steps each instruction through IF/ID/EX/MEM/WB.
//  Handshakes with memory via mem_req/mem_ready and halts on a memory timeout.
// PARAMETERS
//  ALUOP_W      5   width of aluop (matches datapath ALU code)
//  MEM_WAIT_MAX 15  max cycles mem_req may wait for mem_ready before bus error
// PORTS
//  clk         in  1  clock; single clock domain
//  rst_n       in  1  asynchronous active-low reset
//  op          in  6  IR[31:26]
//  funct       in  6  IR[5:0]
//  zero        in  1  ALU zero flag (beq)
//  mem_ready   in  1  memory has completed the current access this cycle
//  mem_req     out 1  memory access request, held until mem_ready
//  i_or_d      out 1  0: address=PC, 1: address=ALUOut
//  mem_write   out 1  write access (valid with mem_req)
//  ir_write    out 1  latch instruction register
//  pc_write    out 1  unconditional PC update
//  pc_wr_cond  out 1  PC update if zero
//  pc_source   out 2  0: ALU result, 1: ALUOut, 2: jump target
//  alu_src_a   out 1  0: PC, 1: rs
//  alu_src_b   out 2  0: rt, 1: const 4, 2: imm, 3: imm<<2
//  if_extend   out 1  1: sign-extend imm, 0: zero-extend
//  aluop       out ALUOP_W  ALU operation code
//  reg_write   out 1  regfile write enable
//  reg_dst     out 1  0: rd, 1: rt
//  memtoreg    out 1  write-back from memory data register
//  bus_err     out 1  sticky: memory timeout occurred
//  illegal     out 1  sticky: undecodable instruction (only with MCTRL_ILLEGAL_TRAP_EN)
//  state_o     out 4  current state (debug)
// BEHAVIOUR
//  Reset: state=S_RST, all outputs 0, wait counter 0. S_RST -> S_IF unconditionally after 1 cycle.
//  Outputs are Moore from state, except ir_write/pc_write in S_IF, which are qualified by mem_ready.
//  S_IF: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, aluop=addu, pc_source=0.
//    On mem_ready: ir_write=1, pc_write=1, -> S_ID. Otherwise stay.
//  S_ID: alu_src_a=0, alu_src_b=3, if_extend=1, aluop=addu (branch target -> ALUOut).
//    Next state by class: R-type -> S_EX_R; addi/addiu/andi/ori/lui -> S_EX_I; lw/sw -> S_EX_ADR;
//    beq -> S_EX_BR; j -> S_EX_J; other -> S_IF (nop) or S_HALT (trap macro).
//  S_EX_R: alu_src_a=1, alu_src_b=0, aluop from funct -> S_WB_R.
//  S_EX_I: alu_src_a=1, alu_src_b=2, aluop/if_extend per op (andi/ori zero-extend) -> S_WB_I.
//  S_EX_ADR: alu_src_a=1, alu_src_b=2, if_extend=1, aluop=add. lw -> S_MEM_RD; sw -> S_MEM_WR.
//  S_EX_BR: alu_src_a=1, alu_src_b=0, aluop=subu, pc_wr_cond=1, pc_source=1 -> S_IF.
//  S_EX_J: pc_write=1, pc_source=2 -> S_IF.
//  S_MEM_RD: mem_req=1, i_or_d=1. On mem_ready -> S_WB_MEM.
//  S_MEM_WR: mem_req=1, mem_write=1, i_or_d=1. On mem_ready -> S_IF. sw never writes the regfile.
//  S_WB_R: reg_write=1, reg_dst=0. S_WB_I: reg_write=1, reg_dst=1. S_WB_MEM: reg_write=1, reg_dst=1, memtoreg=1.
//    All WB states -> S_IF.
//  Latency with zero wait: beq/j 3; R, I-ALU, sw 4; lw 5 cycles.
//  Wait counter:
//    clears on entering any mem state and whenever mem_ready=1;
//    increments each mem_req cycle without mem_ready;
//    if the count reaches MEM_WAIT_MAX with mem_ready=0: -> S_HALT, bus_err=1.
//    mem_ready on the limit cycle wins (no error).
//  S_HALT: all control outputs 0, sticky until rst_n. rst_n low in any state (including mid-access)
//    forces S_RST immediately; mem_req drops asynchronously.
//  mem_ready outside mem states is ignored.
// CONFIGURATION
//  MCTRL_ILLEGAL_TRAP_EN defined: unknown op/funct in S_ID -> S_HALT with illegal=1 (sticky).
//  Undefined: unknown instruction -> S_IF as a nop, and illegal is tied 0.
// STRUCTURE
//  Package mctrl_pkg holds:
//    state encoding (4-bit: S_RST, S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADR, S_EX_BR, S_EX_J,
//      S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_HALT);
//    opcode/funct constants;
//    aluop codes (add 0, addu 1, subu 2, and 3, or 4, slt 5, lui 6);
//    instruction-class enum.
//  Sub-module mctrl_decode: combinational op/funct -> {class, aluop, if_extend, valid}.
//  Top holds the FSM and the wait counter.
// TESTING
//  addu (op 0, funct 0x21), mem_ready=1 every cycle -> states IF,ID,EX_R,WB_R; reg_write=1, reg_dst=0 only in cycle 4.
//  lw (op 0x23), mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles; 5+3 cycles total; memtoreg=1 in WB_MEM.
//  beq with zero=1 and with zero=0 -> pc_wr_cond=1, pc_source=1 in EX_BR; back to IF in cycle 4; no reg_write.
//  sw with mem_ready never asserted -> after MEM_WAIT_MAX cycles: S_HALT, bus_err=1 sticky until rst_n.
//  op 0x3F: with the trap macro -> S_HALT, illegal=1; without it -> S_IF next, illegal=0.
//  rst_n pulsed low in S_MEM_WR -> async S_RST with all outputs 0; then S_IF one cycle after release.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// state encoding, opcode/funct values, ALU codes, instruction classes.
package mctrl_pkg;

   typedef enum logic [3:0] {
      S_RST,
      S_IF,
      S_ID,
      S_EX_R,
      S_EX_I,
      S_EX_ADR,
      S_EX_BR,
      S_EX_J,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_R,
      S_WB_I,
      S_WB_MEM,
      S_HALT
   } state_e;

   typedef enum logic [2:0] {
      CL_BAD,
      CL_R,
      CL_I,
      CL_LW,
      CL_SW,
      CL_BR,
      CL_J
   } iclass_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_ADDU = 3'd1;
   localparam logic [2:0] ALU_SUBU = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;
   localparam logic [2:0] ALU_LUI  = 3'd6;

   function automatic logic is_mem_state(state_e s);
      return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory port handshake between the control FSM (master)
// and the shared instruction/data memory (slave).
interface multicycle_ctrl_if;

   logic mem_req;
   logic mem_ready;
   logic i_or_d;
   logic mem_write;

   modport master (
      output mem_req,
      output i_or_d,
      output mem_write,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  i_or_d,
      input  mem_write,
      output mem_ready
   );

endinterface

// File: rtl/mctrl_decode.sv
// Combinational decode of op/funct into instruction class,
// ALU operation and immediate extension mode.
module mctrl_decode
   import mctrl_pkg::*;
#(
   parameter int ALUOP_W = 5
) (
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   output iclass_e            cls,
   output logic [ALUOP_W-1:0] aluop,
   output logic               if_extend,
   output logic               valid
);

   logic [2:0] alu;

   always_comb begin
      cls       = CL_BAD;
      alu       = ALU_ADD;
      if_extend = 1'b1;
      unique case (op)
         OP_RTYPE: begin
            unique case (funct)
               F_ADD:   begin cls = CL_R; alu = ALU_ADD;  end
               F_ADDU:  begin cls = CL_R; alu = ALU_ADDU; end
               F_SUBU:  begin cls = CL_R; alu = ALU_SUBU; end
               F_AND:   begin cls = CL_R; alu = ALU_AND;  end
               F_OR:    begin cls = CL_R; alu = ALU_OR;   end
               F_SLT:   begin cls = CL_R; alu = ALU_SLT;  end
               default: cls = CL_BAD;
            endcase
         end
         OP_ADDI:  begin cls = CL_I; alu = ALU_ADD;  end
         OP_ADDIU: begin cls = CL_I; alu = ALU_ADDU; end
         OP_ANDI: begin
            cls       = CL_I;
            alu       = ALU_AND;
            if_extend = 1'b0;
         end
         OP_ORI: begin
            cls       = CL_I;
            alu       = ALU_OR;
            if_extend = 1'b0;
         end
         OP_LUI:   begin cls = CL_I;  alu = ALU_LUI;  end
         OP_LW:    begin cls = CL_LW; alu = ALU_ADD;  end
         OP_SW:    begin cls = CL_SW; alu = ALU_ADD;  end
         OP_BEQ:   begin cls = CL_BR; alu = ALU_SUBU; end
         OP_J:     cls = CL_J;
         default:  cls = CL_BAD;
      endcase
   end

   assign aluop = ALUOP_W'(alu);
   assign valid = (cls != CL_BAD);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait-timeout watchdog.
// Define MCTRL_ILLEGAL_TRAP_EN to halt on undecodable instructions.
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int ALUOP_W      = 5,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   multicycle_ctrl_if.master  bus,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_wr_cond,
   output logic [1:0]         pc_source,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               if_extend,
   output logic [ALUOP_W-1:0] aluop,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               memtoreg,
   output logic               bus_err,
   output logic               illegal,
   output logic [3:0]         state_o
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               bus_err_q, bus_err_d;
   logic               mem_req, i_or_d, mem_write;
   logic               rdy;
   iclass_e            dec_cls;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               dec_ext;
   logic               dec_valid;
   logic               unused_zero;

   // Branch resolution happens in the datapath via pc_wr_cond & zero.
   assign unused_zero = zero;
   assign rdy         = bus.mem_ready;

   mctrl_decode #(.ALUOP_W(ALUOP_W)) u_dec (
      .op        (op),
      .funct     (funct),
      .cls       (dec_cls),
      .aluop     (dec_aluop),
      .if_extend (dec_ext),
      .valid     (dec_valid)
   );

`ifdef MCTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bus_err_d  = bus_err_q;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      illegal_d  = illegal_q;
`endif
      mem_req    = 1'b0;
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_wr_cond = 1'b0;
      pc_source  = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      if_extend  = 1'b0;
      aluop      = '0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      memtoreg   = 1'b0;
      unique case (state_q)
         S_RST: state_d = S_IF;
         S_IF: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            aluop     = ALUOP_W'(ALU_ADDU);
            if (rdy) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_ID;
            end
         end
         S_ID: begin
            alu_src_b = 2'd3;
            if_extend = 1'b1;
            aluop     = ALUOP_W'(ALU_ADDU);
            if (!dec_valid) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
               state_d   = S_HALT;
               illegal_d = 1'b1;
`else
               state_d   = S_IF;
`endif
            end else begin
               unique case (dec_cls)
                  CL_R:         state_d = S_EX_R;
                  CL_I:         state_d = S_EX_I;
                  CL_LW, CL_SW: state_d = S_EX_ADR;
                  CL_BR:        state_d = S_EX_BR;
                  CL_J:         state_d = S_EX_J;
                  default:      state_d = S_IF;
               endcase
            end
         end
         S_EX_R: begin
            alu_src_a = 1'b1;
            aluop     = dec_aluop;
            state_d   = S_WB_R;
         end
         S_EX_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            if_extend = dec_ext;
            aluop     = dec_aluop;
            state_d   = S_WB_I;
         end
         S_EX_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            if_extend = 1'b1;
            aluop     = ALUOP_W'(ALU_ADD);
            state_d   = (dec_cls == CL_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_EX_BR: begin
            alu_src_a  = 1'b1;
            aluop      = ALUOP_W'(ALU_SUBU);
            pc_wr_cond = 1'b1;
            pc_source  = 2'd1;
            state_d    = S_IF;
         end
         S_EX_J: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            state_d   = S_IF;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (rdy) state_d = S_WB_MEM;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (rdy) state_d = S_IF;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            state_d   = S_IF;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_IF;
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            memtoreg  = 1'b1;
            state_d   = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
      // A ready on the limit cycle takes the normal path above.
      if (is_mem_state(state_q) && !rdy) begin
         if (cnt_q == LIMIT) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RST;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

`ifdef MCTRL_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign bus.mem_req   = mem_req;
   assign bus.i_or_d    = i_or_d;
   assign bus.mem_write = mem_write;
   assign bus_err       = bus_err_q;
   assign state_o       = state_q;

endmodule
